// File: rtl/iddmm_result_sel.sv
// iddmm_result_sel
//   Consumer end of the IDDMM calculator's result interface. Collects the N
//   unreduced words (a) and the N pre-subtracted words (a-p), latches the
//   end-of-operation sign, then streams the selected operand out LSW first
//   on a valid/ready master port.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   i_wr_en_a / i_wr_data_a    unreduced word write strobe / data (LSW first)
//   i_wr_en_sub / i_wr_data_sub (a-p) word write strobe / data (LSW first)
//   i_cal_done / i_cal_sign    end-of-operation pulse; sign 1 selects (a-p)
//   o_busy                     high while streaming; upstream must hold off
//   m_valid/m_ready/m_data     output word stream
//   m_last                     marks word N-1
//   o_done                     one-cycle pulse after the final handshake
//   o_err                      sticky protocol-error flag (cleared by rst)
module iddmm_result_sel #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr_en_a,
  input  logic [K-1:0] i_wr_data_a,
  input  logic         i_wr_en_sub,
  input  logic [K-1:0] i_wr_data_sub,
  input  logic         i_cal_done,
  input  logic         i_cal_sign,
  output logic         o_busy,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [K-1:0] m_data,
  output logic         m_last,
  output logic         o_done,
  output logic         o_err
);

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;

  // Write counters need one extra bit so that "full" (== N) is representable.
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] RD_LAST  = ADDR_W'(N-1);
  localparam logic [ADDR_W-1:0] RD_ONE   = ADDR_W'(1);

  state_t            state;
  logic [K-1:0]      buf_a [N];
  logic [K-1:0]      buf_s [N];
  logic [ADDR_W:0]   wa;
  logic [ADDR_W:0]   ws;
  logic [ADDR_W-1:0] rd;
  logic              done_lat;
  logic              sign_lat;

  logic in_collect;
  logic in_send;
  logic we_a;
  logic we_s;
  logic take_done;
  logic all_in;
  logic hs;
  logic err_ev;

  assign in_collect = (state == COLLECT);
  assign in_send    = (state == SEND);

  // Accepted events: anything outside these conditions is dropped and flagged.
  assign we_a      = in_collect & i_wr_en_a   & (wa != CNT_FULL);
  assign we_s      = in_collect & i_wr_en_sub & (ws != CNT_FULL);
  assign take_done = in_collect & i_cal_done  & ~done_lat;

  // Evaluated on registered values only, so the last event takes effect one
  // edge before the stream starts.
  assign all_in = (wa == CNT_FULL) & (ws == CNT_FULL) & done_lat;

  assign err_ev = (in_collect & ((i_wr_en_a   & (wa == CNT_FULL)) |
                                 (i_wr_en_sub & (ws == CNT_FULL)) |
                                 (i_cal_done  & done_lat)))
                | (in_send & (i_wr_en_a | i_wr_en_sub | i_cal_done));

  // Outputs decode straight from registered state; m_valid is high for the
  // whole of SEND, so no bubbles appear between words.
  assign m_valid = in_send;
  assign o_busy  = in_send;
  assign m_last  = in_send & (rd == RD_LAST);
  assign m_data  = in_send ? (sign_lat ? buf_s[rd] : buf_a[rd]) : '0;
  assign hs      = m_valid & m_ready;

  // NOTE: the word buffers carry no reset -- their contents are don't-care
  // until written, and leaving them out of the reset tree keeps them plain
  // register files.
  always_ff @(posedge clk) begin
    if (we_a) buf_a[wa[ADDR_W-1:0]] <= i_wr_data_a;
    if (we_s) buf_s[ws[ADDR_W-1:0]] <= i_wr_data_sub;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= COLLECT;
      wa       <= '0;
      ws       <= '0;
      rd       <= '0;
      done_lat <= 1'b0;
      sign_lat <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (err_ev) o_err <= 1'b1;

      case (state)
        COLLECT: begin
          if (we_a) wa <= wa + CNT_ONE;
          if (we_s) ws <= ws + CNT_ONE;
          if (take_done) begin
            done_lat <= 1'b1;
            sign_lat <= i_cal_sign;
          end
          if (all_in) begin
            state <= SEND;
            rd    <= '0;
          end
        end

        SEND: begin
          if (hs) begin
            if (rd == RD_LAST) begin
              state    <= COLLECT;
              wa       <= '0;
              ws       <= '0;
              rd       <= '0;
              done_lat <= 1'b0;
              o_done   <= 1'b1;
            end else begin
              rd <= rd + RD_ONE;
            end
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_iddmm_result_sel.sv
// Self-checking bench for iddmm_result_sel (K=8, N=4). Stimulus pushes the
// expected output operand into a scoreboard queue; a negedge monitor pops and
// compares on every handshake and checks the o_done pulse timing.
module tb_iddmm_result_sel;
  localparam int K = 8;
  localparam int N = 4;

  typedef struct {
    logic [K-1:0] data;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_wr_en_a = 1'b0;
  logic [K-1:0] i_wr_data_a = '0;
  logic         i_wr_en_sub = 1'b0;
  logic [K-1:0] i_wr_data_sub = '0;
  logic         i_cal_done = 1'b0;
  logic         i_cal_sign = 1'b0;
  logic         o_busy;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [K-1:0] m_data;
  logic         m_last;
  logic         o_done;
  logic         o_err;

  exp_t         exp_q[$];
  logic         ready_pat[$];
  int           ready_mode = 0;   // 0: always ready, 1: random, 2: pattern queue
  int           checks = 0;
  int           errors = 0;
  int           hs_count = 0;
  bit           done_pend = 1'b0;
  logic [K-1:0] va[N];
  logic [K-1:0] vs[N];

  iddmm_result_sel #(.K(K), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_wr_en_a    (i_wr_en_a),
    .i_wr_data_a  (i_wr_data_a),
    .i_wr_en_sub  (i_wr_en_sub),
    .i_wr_data_sub(i_wr_data_sub),
    .i_cal_done   (i_cal_done),
    .i_cal_sign   (i_cal_sign),
    .o_busy       (o_busy),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of upstream activity, applied from posedge+1 to the next posedge+1.
  task automatic drive(input logic ea, input logic [K-1:0] da, input logic es,
                       input logic [K-1:0] ds, input logic cd, input logic sg);
    i_wr_en_a     = ea;
    i_wr_data_a   = da;
    i_wr_en_sub   = es;
    i_wr_data_sub = ds;
    i_cal_done    = cd;
    i_cal_sign    = sg;
    tick();
    i_wr_en_a   = 1'b0;
    i_wr_en_sub = 1'b0;
    i_cal_done  = 1'b0;
  endtask

  // Reference: the output is simply the operand chosen by the sign, LSW first.
  task automatic push_exp(input logic sg);
    for (int i = 0; i < N; i++) begin
      exp_t e;
      e.data = sg ? vs[i] : va[i];
      e.last = (i == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_words();
    for (int i = 0; i < N; i++) begin
      va[i] = K'($urandom);
      vs[i] = K'($urandom);
    end
  endtask

  task automatic load_all(input logic sg);
    for (int i = 0; i < N; i++) drive(1'b1, va[i], 1'b1, vs[i], 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1, sg);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (o_done) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_o_busy",  32'(o_busy),  32'd0);
    check("rst_o_done",  32'(o_done),  32'd0);
    check("rst_o_err",   32'(o_err),   32'd0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Downstream ready generator, updated at posedge+2 so stimulus at +1 can
  // reconfigure it for the very next cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = (ready_pat.size() > 0) ? ready_pat.pop_front() : 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      done_pend = 1'b0;
    end else begin
      check("o_done_pulse", 32'(o_done), 32'(done_pend));
      done_pend = 1'b0;
      if (m_valid) begin
        check("busy_in_send", 32'(o_busy), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(m_valid), 32'd0);
        end else begin
          check("m_data", 32'(m_data), 32'(exp_q[0].data));
          check("m_last", 32'(m_last), 32'(exp_q[0].last));
          if (m_ready) begin
            hs_count++;
            if (exp_q[0].last) done_pend = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h0;
    int n;
    logic sg;
    logic ea, es, cd;
    int ia, is;
    bit dn;

    // Reset state
    #1;
    check("reset_m_valid", 32'(m_valid), 32'd0);
    check("reset_o_busy",  32'(o_busy),  32'd0);
    check("reset_m_last",  32'(m_last),  32'd0);
    check("reset_m_data",  32'(m_data),  32'd0);
    check("reset_o_err",   32'(o_err),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // 1. Basic select-a, full throughput
    va = '{8'h11, 8'h22, 8'h33, 8'h44};
    vs = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_exp(1'b0);
    load_all(1'b0);
    check("t1_valid_lat0", 32'(m_valid), 32'd0);
    tick();
    check("t1_valid_rise", 32'(m_valid), 32'd1);
    check("t1_busy", 32'(o_busy), 32'd1);
    repeat (N) tick();
    check("t1_throughput_done", 32'(o_done), 32'd1);
    check("t1_err", 32'(o_err), 32'd0);
    tick();

    // 2. Select-sub, cal_done first, interleaved words
    push_exp(1'b1);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) begin
      drive(1'b1, va[i], 1'b0, '0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, vs[i], 1'b0, 1'b0);
    end
    check("t2_valid_lat0", 32'(m_valid), 32'd0);
    tick();
    check("t2_valid_rise", 32'(m_valid), 32'd1);
    wait_done("t2_done", 20);
    check("t2_err", 32'(o_err), 32'd0);

    // 3. Back-pressure
    va = '{8'h5a, 8'ha5, 8'h3c, 8'hc3};
    push_exp(1'b0);
    load_all(1'b0);
    tick();
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    ready_mode = 2;
    h0 = hs_count;
    wait_done("t3_done", 40);
    check("t3_handshakes", 32'(hs_count - h0), 32'd4);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);
    ready_mode = 0;

    // 4. Overflow, write during SEND, cal_done during SEND
    va = '{8'h11, 8'h22, 8'h33, 8'h44};
    vs = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_exp(1'b0);
    for (int i = 0; i < N; i++) drive(1'b1, va[i], 1'b1, vs[i], 1'b0, 1'b0);
    check("t4_err_before", 32'(o_err), 32'd0);
    drive(1'b1, 8'h55, 1'b0, '0, 1'b0, 1'b0);
    check("t4_err_overflow", 32'(o_err), 32'd1);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    tick();
    ready_pat = '{1'b0, 1'b0, 1'b0, 1'b0};
    ready_mode = 2;
    drive(1'b1, 8'hee, 1'b1, 8'hee, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    wait_done("t4_done", 40);
    check("t4_err_sticky", 32'(o_err), 32'd1);
    ready_mode = 0;
    apply_reset();

    // 4b. Second cal_done while one is already latched
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    check("t4b_err_first_done", 32'(o_err), 32'd0);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    check("t4b_err_double_done", 32'(o_err), 32'd1);
    apply_reset();

    // 5. Reset mid-stream, then a fresh operation
    push_exp(1'b1);
    load_all(1'b1);
    h0 = hs_count;
    n = 0;
    tick();
    while ((hs_count - h0) < 2 && n < 20) begin
      tick();
      n++;
    end
    check("t5_two_handshakes", 32'(hs_count - h0), 32'd2);
    apply_reset();
    rand_words();
    push_exp(1'b0);
    load_all(1'b0);
    wait_done("t5_fresh_done", 20);
    check("t5_err", 32'(o_err), 32'd0);

    // 6. Back-to-back operations
    rand_words();
    push_exp(1'b0);
    load_all(1'b0);
    wait_done("t6_first_done", 20);
    rand_words();
    push_exp(1'b1);
    load_all(1'b1);
    wait_done("t6_second_done", 20);
    check("t6_err", 32'(o_err), 32'd0);

    // Randomized operations: random interleaving and random back-pressure
    ready_mode = 1;
    for (int op = 0; op < 20; op++) begin
      rand_words();
      sg = 1'($urandom_range(0, 1));
      push_exp(sg);
      ia = 0;
      is = 0;
      dn = 1'b0;
      while (ia < N || is < N || !dn) begin
        ea = (ia < N) && ($urandom_range(0, 1) == 1);
        es = (is < N) && ($urandom_range(0, 1) == 1);
        cd = !dn && ($urandom_range(0, 3) == 0);
        drive(ea, ea ? va[ia] : '0, es, es ? vs[is] : '0, cd, sg);
        if (ea) ia++;
        if (es) is++;
        if (cd) dn = 1'b1;
      end
      wait_done("rand_done", 200);
    end
    ready_mode = 0;
    check("final_err", 32'(o_err), 32'd0);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
